// File: rtl/register_access_controller_pkg.sv
// rtl/register_access_controller_pkg.sv - shared constants and FSM encoding for the register access controller
// Contents: DEFAULT_WIDTH (operand/result register width), 3-bit binary state
// encodings and the state_t enum built from them.
`timescale 1ns/1ps
package register_access_controller_pkg;

    // Width shared by the multiplier operand/result register instances.
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WRITE  = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_RDWAIT = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        WRITE  = ST_WRITE,
        READ   = ST_READ,
        RDWAIT = ST_RDWAIT,
        RESP   = ST_RESP
    } state_t;

endpackage

// File: rtl/register_access_controller.sv
// rtl/register_access_controller.sv - valid/ready initiator for one N-bit storage register
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   reqValid/reqReady/reqWrite/reqData : request channel (write data or read command)
//   rspValid/rspReady/rspData     : read response channel
//   regDataIn/regWriteEnable/regReadEnable : drive the target register
//   regDataOut/regAccessError     : sampled from the target register
//   errorSticky                   : latched regAccessError, cleared only by reset
//   busy                          : controller not in IDLE
`timescale 1ns/1ps
module register_access_controller
    import register_access_controller_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqValid,
    output logic         reqReady,
    input  logic         reqWrite,
    input  logic [N-1:0] reqData,
    output logic         rspValid,
    input  logic         rspReady,
    output logic [N-1:0] rspData,
    output logic [N-1:0] regDataIn,
    output logic         regWriteEnable,
    output logic         regReadEnable,
    input  logic [N-1:0] regDataOut,
    input  logic         regAccessError,
    output logic         errorSticky,
    output logic         busy
);

    state_t state;

    // Gated by reset so nothing is accepted in a cycle whose edge resets us.
    assign reqReady = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            regWriteEnable <= 1'b0;
            regReadEnable  <= 1'b0;
            regDataIn      <= '0;
            rspValid       <= 1'b0;
            rspData        <= '0;
            errorSticky    <= 1'b0;
        end else begin
            // Diagnostic only; the sequencing below ignores it.
            if (regAccessError) begin
                errorSticky <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (reqWrite) begin
                            regDataIn      <= reqData;
                            regWriteEnable <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            regReadEnable  <= 1'b1;
                            state          <= READ;
                        end
                    end
                end

                WRITE: begin
                    regWriteEnable <= 1'b0;
                    state          <= IDLE;
                end

                // The register loads dataOut at the edge closing this state.
                READ: begin
                    regReadEnable <= 1'b0;
                    state         <= RDWAIT;
                end

                RDWAIT: begin
                    rspData  <= regDataOut;
                    rspValid <= 1'b1;
                    state    <= RESP;
                end

                RESP: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    regWriteEnable <= 1'b0;
                    regReadEnable  <= 1'b0;
                    rspValid       <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_access_controller.sv
// tb/tb_register_access_controller.sv - directed and random bench for register_access_controller
`timescale 1ns/1ps
module tb_register_access_controller;
    import register_access_controller_pkg::*;

    localparam int N = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         reqValid = 1'b0;
    logic         reqReady;
    logic         reqWrite = 1'b0;
    logic [N-1:0] reqData = '0;
    logic         rspValid;
    logic         rspReady = 1'b0;
    logic [N-1:0] rspData;
    logic [N-1:0] regDataIn;
    logic         regWriteEnable;
    logic         regReadEnable;
    logic [N-1:0] regDataOut;
    logic         regAccessError;
    logic         errorSticky;
    logic         busy;
    logic         force_err = 1'b0;

    int           total = 0;
    int           bad = 0;
    int           viol = 0;
    logic [N-1:0] model_reg = '0;

    always #5 clk = ~clk;

    register_access_controller #(.N(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqData        (reqData),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspData        (rspData),
        .regDataIn      (regDataIn),
        .regWriteEnable (regWriteEnable),
        .regReadEnable  (regReadEnable),
        .regDataOut     (regDataOut),
        .regAccessError (regAccessError),
        .errorSticky    (errorSticky),
        .busy           (busy)
    );

    // Target storage register: one-cycle enables, dataOut loads on read.
    logic [N-1:0] reg_store;
    logic [N-1:0] reg_dout;
    always @(posedge clk) begin
        if (reset) begin
            reg_store <= '0;
            reg_dout  <= '0;
        end else begin
            if (regWriteEnable) reg_store <= regDataIn;
            if (regReadEnable)  reg_dout  <= reg_store;
        end
    end
    assign regDataOut     = reg_dout;
    assign regAccessError = (regWriteEnable && regReadEnable) || force_err;

    always @(negedge clk) begin
        if (!reset && ((regWriteEnable && regReadEnable) || (regAccessError && !force_err)))
            viol++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [N-1:0] d);
        reqValid = 1'b1; reqWrite = 1'b1; reqData = d;
        tick();
        reqValid = 1'b0;
        tick();
        model_reg = d;
    endtask

    task automatic do_read(output logic [N-1:0] d, output logic ok);
        int cyc;
        ok = 1'b0; d = '0;
        reqValid = 1'b1; reqWrite = 1'b0; reqData = '1;
        tick();
        reqValid = 1'b0;
        rspReady = 1'b1;
        cyc = 0;
        while (!rspValid && cyc < 20) begin tick(); cyc++; end
        if (rspValid) begin
            ok = 1'b1;
            d = rspData;
            tick();
        end
        rspReady = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; reqValid = 1'b1; reqWrite = 1'b1; reqData = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({reqReady, regWriteEnable, regReadEnable, rspValid, errorSticky, busy} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d got=%b exp=000000", i,
                         {reqReady, regWriteEnable, regReadEnable, rspValid, errorSticky, busy});
            end
        end
        total++;
        if (rspData !== '0 || regDataIn !== '0) begin
            bad++;
            $display("FAIL reset_data got rspData=%h regDataIn=%h exp=0", rspData, regDataIn);
        end
        reset = 1'b0; reqValid = 1'b0;
        tick();
        total++;
        if (reqReady !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got reqReady=%b busy=%b exp=1/0", reqReady, busy);
        end
    endtask

    task automatic test_write_read();
        reqValid = 1'b1; reqWrite = 1'b1; reqData = 32'hDEADBEEF;
        tick();
        reqValid = 1'b0;
        total++;
        if ({regWriteEnable, regReadEnable, busy, reqReady} !== 4'b1010 || regDataIn !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_pulse got we/re/busy/rdy=%b data=%h exp=1010 deadbeef",
                     {regWriteEnable, regReadEnable, busy, reqReady}, regDataIn);
        end
        tick();
        total++;
        if (regWriteEnable !== 1'b0 || reqReady !== 1'b1) begin
            bad++;
            $display("FAIL write_end got we=%b rdy=%b exp=0 1", regWriteEnable, reqReady);
        end
        model_reg = 32'hDEADBEEF;
        reqValid = 1'b1; reqWrite = 1'b0; reqData = 32'h5555_5555;
        tick();
        reqValid = 1'b0;
        total++;
        if (regReadEnable !== 1'b1 || regWriteEnable !== 1'b0 || rspValid !== 1'b0) begin
            bad++;
            $display("FAIL read_pulse got re=%b we=%b rv=%b exp=1 0 0", regReadEnable, regWriteEnable, rspValid);
        end
        tick();
        total++;
        if (regReadEnable !== 1'b0 || rspValid !== 1'b0) begin
            bad++;
            $display("FAIL read_wait got re=%b rv=%b exp=0 0", regReadEnable, rspValid);
        end
        tick();
        total++;
        if (rspValid !== 1'b1 || rspData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_rsp got rv=%b data=%h exp=1 deadbeef", rspValid, rspData);
        end
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        total++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1 || rspData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_done got rv=%b rdy=%b data=%h exp=0 1 deadbeef", rspValid, reqReady, rspData);
        end
    endtask

    task automatic test_backpressure();
        logic hold_ok;
        reqValid = 1'b1; reqWrite = 1'b0; reqData = 32'h0BAD_0BAD;
        rspReady = 1'b0;
        tick(); tick(); tick();
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rspValid !== 1'b1 || rspData !== 32'hDEADBEEF || reqReady !== 1'b0 ||
                regWriteEnable !== 1'b0 || regReadEnable !== 1'b0) begin
                hold_ok = 1'b0;
                $display("FAIL bp_hold cycle=%0d got rv=%b data=%h rdy=%b we=%b re=%b exp=1 deadbeef 0 0 0",
                         i, rspValid, rspData, reqReady, regWriteEnable, regReadEnable);
            end
            tick();
        end
        total++;
        if (hold_ok !== 1'b1) bad++;
        rspReady = 1'b1;
        tick();
        total++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got rv=%b rdy=%b exp=0 1", rspValid, reqReady);
        end
        reqValid = 1'b0; rspReady = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int viol_start;
        int cyc;
        logic wr;
        logic got;
        logic [N-1:0] d;
        viol_start = viol;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                reqValid = 1'b0;
                tick();
            end
            wr = ($urandom_range(0, 1) == 1);
            d = $urandom;
            reqValid = 1'b1; reqWrite = wr; reqData = d;
            rspReady = ($urandom_range(0, 1) == 1);
            tick();
            reqValid = 1'b0;
            if (wr) model_reg = d;
            got = 1'b0;
            cyc = 0;
            while (busy && cyc < 40) begin
                rspReady = (cyc > 20) || ($urandom_range(0, 1) == 1);
                if (rspValid && rspReady) begin
                    got = 1'b1;
                    total++;
                    if (rspData !== model_reg) begin
                        bad++;
                        $display("FAIL rand_read idx=%0d got=%h exp=%h", i, rspData, model_reg);
                    end
                end
                tick();
                cyc++;
            end
            if (busy || (!wr && !got)) begin
                total++; bad++;
                $display("FAIL rand_timeout idx=%0d got busy=%b rsp=%b exp=0 1", i, busy, got);
            end
        end
        rspReady = 1'b0;
        total++;
        if (viol - viol_start !== 0 || errorSticky !== 1'b0) begin
            bad++;
            $display("FAIL rand_invariants got viol=%0d sticky=%b exp=0 0", viol - viol_start, errorSticky);
        end
    endtask

    task automatic test_error();
        logic [N-1:0] d;
        logic ok;
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        total++;
        if (errorSticky !== 1'b1 || busy !== 1'b0 || reqReady !== 1'b1) begin
            bad++;
            $display("FAIL err_set got sticky=%b busy=%b rdy=%b exp=1 0 1", errorSticky, busy, reqReady);
        end
        do_write(32'hA5A5_5A5A);
        do_read(d, ok);
        total++;
        if (ok !== 1'b1 || d !== 32'hA5A5_5A5A || errorSticky !== 1'b1) begin
            bad++;
            $display("FAIL err_fsm got ok=%b data=%h sticky=%b exp=1 a5a55a5a 1", ok, d, errorSticky);
        end
    endtask

    task automatic test_reset_mid_read();
        logic seen;
        logic [N-1:0] d;
        logic ok;
        do_write(32'h0000_1234);
        reqValid = 1'b1; reqWrite = 1'b0;
        tick();
        reqValid = 1'b0;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        tick();
        total++;
        if (rspValid !== 1'b0 || busy !== 1'b0 || errorSticky !== 1'b0) begin
            bad++;
            $display("FAIL midrd_reset got rv=%b busy=%b sticky=%b exp=0 0 0", rspValid, busy, errorSticky);
        end
        tick();
        reset = 1'b0;
        model_reg = '0;
        for (int i = 0; i < 5; i++) begin
            if (rspValid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL midrd_dropped got rspValid_seen=%b exp=0", seen);
        end
        do_read(d, ok);
        total++;
        if (ok !== 1'b1 || d !== 32'h0) begin
            bad++;
            $display("FAIL midrd_fresh got ok=%b data=%h exp=1 00000000", ok, d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_random();
        test_error();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
